// File: rtl/vga_pkg.sv
// Shared constants and width helpers for the text-mode pixel pipeline.
package vga_pkg;

    // Bit positions within the per-character attribute field
    localparam int unsigned ATTR_BLINK = 0;
    localparam int unsigned ATTR_INV   = 1;
    localparam int unsigned ATTR_UL    = 2;

    // Common 24-bit colours
    localparam logic [23:0] COLOR_BLACK = 24'h000000;
    localparam logic [23:0] COLOR_WHITE = 24'hFFFFFF;

    // Index width for a range of n items (never less than one bit)
    function automatic int unsigned vga_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Font ROM address width: character code followed by glyph row
    function automatic int unsigned vga_addr_w(input int unsigned code_w,
                                               input int unsigned char_h);
        return code_w + vga_w(char_h);
    endfunction

endpackage

// File: rtl/vga_blink_timer.sv
// Frame-counting blink timer: blink_phase toggles every BLINK_FRAMES frames.
module vga_blink_timer
    import vga_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    output logic blink_phase
);

    localparam int unsigned CNT_W = vga_w(BLINK_FRAMES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] count;

    // Count frame pulses; on the last one of a half-period wrap and flip phase
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (count == LAST) begin
                count       <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_text_pixel.sv
// Pipelined text-mode pixel generator: font ROM fetch plus per-character
// colour, invert, underline, blink and block cursor. Latency FONT_LAT+2.
module vga_text_pixel
    import vga_pkg::*;
#(
    parameter int unsigned CHAR_W       = 12,
    parameter int unsigned CHAR_H       = 16,
    parameter int unsigned CODE_W       = 8,
    parameter int unsigned COLOR_W      = 24,
    parameter int unsigned FONT_LAT     = 1,
    parameter int unsigned BLINK_FRAMES = 32,
    parameter int unsigned CURSOR_ROW   = 14
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic [vga_w(CHAR_H)-1:0]              in_row,
    input  logic [vga_w(CHAR_W)-1:0]              in_col,
    input  logic [CODE_W-1:0]                     in_code,
    input  logic [COLOR_W-1:0]                    in_fg,
    input  logic [COLOR_W-1:0]                    in_bg,
    input  logic [2:0]                            in_attr,
    input  logic                                  in_cursor,
    input  logic                                  cursor_en,
    input  logic                                  frame_start,
    output logic [vga_addr_w(CODE_W, CHAR_H)-1:0] font_addr,
    input  logic [CHAR_W-1:0]                     font_row,
    output logic                                  out_valid,
    output logic [COLOR_W-1:0]                    out_data
);

    localparam int unsigned ROW_W  = vga_w(CHAR_H);
    localparam int unsigned COL_W  = vga_w(CHAR_W);
    localparam int unsigned ADDR_W = vga_addr_w(CODE_W, CHAR_H);
    localparam int unsigned DEPTH  = FONT_LAT + 1;

    // Everything the output stage needs besides the glyph row itself;
    // row-derived tests are resolved up front so the row need not travel.
    typedef struct packed {
        logic               valid;
        logic [COL_W-1:0]   col;
        logic [COLOR_W-1:0] fg;
        logic [COLOR_W-1:0] bg;
        logic [2:0]         attr;
        logic               cursor_hit;
        logic               phase;
        logic               row_bad;
        logic               col_bad;
        logic               ul_row;
    } side_t;

    side_t              sb [DEPTH];
    side_t              sb_in;
    side_t              st;
    logic               blink_phase;
    logic [31:0]        row_ext;
    logic [31:0]        col_ext;
    logic [ROW_W-1:0]   row_eff;
    logic [ADDR_W-1:0]  addr_next;
    logic [CHAR_W-1:0]  mask;
    logic               on;
    logic [COLOR_W-1:0] pix_next;

    vga_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .blink_phase(blink_phase)
    );

    // Input stage decode: clamp out-of-range rows, form the ROM address
    // and pack the sideband word that travels alongside the fetch.
    always_comb begin
        sb_in   = '0;
        row_ext = 32'(in_row);
        col_ext = 32'(in_col);

        sb_in.row_bad = (row_ext >= CHAR_H);
        sb_in.col_bad = (col_ext >= CHAR_W);
        row_eff       = sb_in.row_bad ? '0 : in_row;
        addr_next     = ADDR_W'(in_code) * ADDR_W'(CHAR_H) + ADDR_W'(row_eff);

        sb_in.valid      = in_valid;
        sb_in.col        = in_col;
        sb_in.fg         = in_fg;
        sb_in.bg         = in_bg;
        sb_in.attr       = in_attr;
        sb_in.phase      = blink_phase;
        sb_in.ul_row     = (row_ext == CHAR_H - 1);
        sb_in.cursor_hit = in_cursor & cursor_en & (row_ext >= CURSOR_ROW);
    end

    // Address register and sideband shift line, sized to meet font_row
    always_ff @(posedge clk) begin
        if (rst) begin
            font_addr <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                sb[k] <= '0;
            end
        end else begin
            if (in_valid) begin
                font_addr <= addr_next;
            end
            sb[0] <= sb_in;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    // Pixel decision: glyph bit, then underline, blink, invert, cursor
    always_comb begin
        st   = sb[FONT_LAT];
        mask = CHAR_W'(1) << st.col;
        on   = (|(font_row & mask)) & ~st.col_bad & ~st.row_bad;

        if (st.attr[ATTR_UL] && st.ul_row) begin
            on = 1'b1;
        end
        if (st.attr[ATTR_BLINK] && st.phase) begin
            on = 1'b0;
        end
        if (st.attr[ATTR_INV]) begin
            on = ~on;
        end
        if (st.cursor_hit && !st.phase) begin
            on = ~on;
        end

        pix_next = st.valid ? (on ? st.fg : st.bg) : '0;
    end

    // Output register; data forced to zero whenever the slot is empty
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= st.valid;
            out_data  <= pix_next;
        end
    end

endmodule

// File: doc/vga_text_pixel.md
Name: vga_text_pixel

Overview:
- Parametrised, pipelined text-mode pixel generator: takes the character code, colour and attribute bits for the current pixel, fetches the glyph row from an external font ROM and emits the final pixel colour.
- Adds per-character foreground/background colour, invert, underline, frame-based blink, a blinking block cursor and a proper valid pipeline with no latches.
- Sits between the character/attribute RAM readout and the VGA timing/output stage.

Parameters:
- CHAR_W, 12, glyph width in pixels; font_row width.
- CHAR_H, 16, glyph height in rows.
- CODE_W, 8, character code width.
- COLOR_W, 24, pixel colour width.
- FONT_LAT, 1, font ROM read latency in clocks (≥1).
- BLINK_FRAMES, 32, frame_start pulses per blink half-period (≥1).
- CURSOR_ROW, 14, first glyph row covered by the cursor block (0..CHAR_H-1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  pixel request valid this cycle.
- in_row  input  $clog2(CHAR_H)  row within glyph.
- in_col  input  $clog2(CHAR_W)  column within glyph.
- in_code  input  CODE_W  character code.
- in_fg  input  COLOR_W  foreground colour.
- in_bg  input  COLOR_W  background colour.
- in_attr  input  3  [0] blink, [1] invert, [2] underline.
- in_cursor  input  1  this character cell holds the cursor.
- cursor_en  input  1  global cursor enable.
- frame_start  input  1  one-cycle pulse at start of each frame.
- font_addr  output  CODE_W+$clog2(CHAR_H)  font ROM read address (registered).
- font_row  input  CHAR_W  glyph row, valid FONT_LAT cycles after font_addr.
- out_valid  output  1  out_data valid.
- out_data  output  COLOR_W  final pixel colour.

Behaviour:
- Single clock clk; reset rst synchronous, active-high.
- Reset: font_addr=0, out_valid=0, out_data=0, all pipeline valid bits 0, blink counter 0, blink_phase 0.
- Latency: request sampled at edge t -> font_addr registered at t+1 -> font_row valid at t+1+FONT_LAT -> out_valid/out_data registered at t+2+FONT_LAT. Total latency L=FONT_LAT+2; throughput one pixel per clock, no stalls.
- font_addr = in_code*CHAR_H + row_eff; row_eff = in_row if in_row<CHAR_H, else 0. Arithmetic is done at full address width, no truncation.
- Sidebands (col, fg, bg, attr, cursor flag, blink_phase, row-out-of-range flags, valid) travel through a shift register of depth FONT_LAT+1, aligned with font_row.
- glyph = font_row[col] (bit 0 = leftmost column); forced 0 if col≥CHAR_W or row≥CHAR_H.
- on = glyph. Apply in order:
  - underline && row==CHAR_H-1 -> on=1.
  - blink && blink_phase==1 -> on=0.
  - invert -> on=~on.
  - cursor && cursor_en && blink_phase==0 && row≥CURSOR_ROW -> on=~on.
- out_data = on ? fg : bg when the output stage is valid; out_data=0 when invalid.
- Blink timer: counts frame_start pulses 0..BLINK_FRAMES-1. On the pulse at count BLINK_FRAMES-1, count wraps to 0 and blink_phase toggles.
- blink_phase is sampled at the input stage. A pixel sampled in the same cycle as the toggling frame_start uses the old phase.
- Asserting rst mid-stream flushes all in-flight pixels: out_valid=0 from the cycle after the reset edge; no stale pixel emerges after reset deasserts.
- frame_start and in_valid are independent and may coincide.

Decomposition:
- Package vga_pkg holds:
  - attribute bit indices ATTR_BLINK=0, ATTR_INV=1, ATTR_UL=2;
  - colour constants COLOR_BLACK, COLOR_WHITE;
  - a width helper function for row, col and address widths.
- One sub-module, vga_blink_timer (clk, rst, frame_start -> blink_phase), parametrised by BLINK_FRAMES.
- The font ROM is external; the bench supplies a latency-FONT_LAT model.

Test Plan:
- Basic glyph: FONT_LAT=1, font model code 8'h41 row 3 = 12'h0F0. Send code 8'h41, row 3, col 0..11, fg=FFFFFF, bg=000000, attr 0 -> cols 4..7 FFFFFF, others 000000; out_valid exactly 3 cycles after each request; font_addr=0x413.
- Attributes: same pixel stream. invert -> cols 4..7 000000, others FFFFFF. Underline on row 15, glyph row 0 -> all 12 pixels fg.
- Blink: BLINK_FRAMES=2, blink attr set. Phase 0 -> glyph visible. After 2 frame_start pulses -> all pixels bg. After 4 pulses -> glyph visible again. A pixel sent in the same cycle as the toggling pulse uses the old phase.
- Cursor: cursor_en=1, in_cursor=1, CURSOR_ROW=14, blank glyph, fg=00FF00, bg=000000. Rows 14,15 -> 00FF00; rows 0..13 -> 000000; blink_phase 1 -> all rows 000000.
- Latency sweep and bounds: FONT_LAT=3 -> output exactly 5 cycles after request. in_col=13 with CHAR_W=12 -> bg. in_row≥CHAR_H (widened in_row, e.g. CHAR_H=12) -> bg, and font_addr uses row 0.
- Reset mid-stream: 10 back-to-back valid pixels, rst pulsed 1 cycle after the 4th -> out_valid=0 and out_data=0 from the next cycle until new requests have been through L cycles; blink counter and phase reset to 0.
